// File: rtl/pb_edge_pio_pkg.sv
// Shared constants for the pushbutton PIO: Avalon-MM data width and register word addresses.
package pb_edge_pio_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/pb_edge_pio_if.sv
// Avalon-MM slave bus of the pushbutton PIO; the CPU side is the master, the PIO the slave.
interface pb_edge_pio_if;
    import pb_edge_pio_pkg::*;

    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    word_t      writedata;
    word_t      readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pb_debounce.sv
// One pushbutton bit: 2-flop synchroniser, plus a stability counter when
// PB_EDGE_PIO_DEBOUNCE_EN is defined (otherwise the synchronised bit is passed straight out).
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_deb
);

    logic r_sync1, r_sync2;

    // Reset to released (1) so a button held through reset is still seen as one press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PB_EDGE_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_deb, w_deb_d;

    always_comb begin
        w_cnt_d = '0;
        w_deb_d = r_deb;
        if (r_sync2 != r_deb) begin
            if (r_cnt == CntMax) begin
                w_deb_d = r_sync2;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
        end else begin
            r_cnt <= w_cnt_d;
            r_deb <= w_deb_d;
        end
    end

    assign o_deb = r_deb;
`else
    assign o_deb = r_sync2;
`endif

endmodule

// File: rtl/pb_edge_pio.sv
// Pushbutton PIO: debounced inputs, falling-edge capture (RW1C), IRQ mask and level IRQ.
// Debounce counters are built only when PB_EDGE_PIO_DEBOUNCE_EN is defined.
module pb_edge_pio
    import pb_edge_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    pb_edge_pio_if.slave     avs,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] r_deb_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edgecap_d;
    logic             w_wr;
    word_t            w_rdata;
    word_t            r_readdata;
    logic             r_irq;
    logic             w_unused_wdata;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
        pb_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .i_in   (in_port[gi]),
            .o_deb  (w_deb[gi])
        );
    end

    assign w_wr           = avs.chipselect & ~avs.write_n;
    assign w_unused_wdata = ^avs.writedata;

    always_comb begin
        w_fall      = r_deb_prev & ~w_deb;
        w_clr       = (w_wr && avs.address == ADDR_EDGECAP) ? avs.writedata[WIDTH-1:0] : '0;
        // A press landing in the same cycle as its clear must not be lost.
        w_edgecap_d = (r_edgecap & ~w_clr) | w_fall;

        w_rdata = '0;
        case (avs.address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_deb;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_prev <= '1;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_deb_prev <= w_deb;
            r_edgecap  <= w_edgecap_d;
            r_readdata <= w_rdata;
            r_irq      <= |(r_edgecap & r_irqmask);
            if (w_wr && avs.address == ADDR_IRQMASK) begin
                r_irqmask <= avs.writedata[WIDTH-1:0];
            end
        end
    end

    assign avs.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pb_edge_pio.sv
// Self-checking bench for pb_edge_pio (WIDTH=2, DEBOUNCE_CYCLES=4) against a window-based model.
module tb_pb_edge_pio;

    localparam int W  = 2;
    localparam int DC = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    pb_edge_pio_if bus_if ();

    pb_edge_pio #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .avs    (bus_if),
        .in_port(in_port),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk  = 0;
    int fail = 0;

    // Model state: synchronised input, debounced value, previous debounced, registers.
    logic [W-1:0]  m_s1, m_s2, m_deb, m_prev, m_ec, m_mask;
    logic [31:0]   m_rd;
    logic          m_irq;
    logic [W-1:0]  m_hist[$];

    function automatic logic [W-1:0] model_deb();
`ifdef PB_EDGE_PIO_DEBOUNCE_EN
        return m_deb;
`else
        return m_s2;
`endif
    endfunction

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_deb = '1; m_prev = '1;
        m_ec = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
        m_hist.delete();
    endtask

    task automatic bus_set(input logic cs, input logic wn, input logic [1:0] a,
                           input logic [31:0] d);
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.address    = a;
        bus_if.writedata  = d;
    endtask

    // One rising edge; the model advances from the inputs held before the edge.
    task automatic tick();
        logic [W-1:0] deb_pre, clr;
        logic         wr;
        bit           all_diff;
        @(posedge clk);
        if (reset_n) begin
            deb_pre = model_deb();
            wr      = bus_if.chipselect && !bus_if.write_n;
            clr     = (wr && bus_if.address == 2'd3) ? bus_if.writedata[W-1:0] : '0;
            case (bus_if.address)
                2'd0:    m_rd = 32'(deb_pre);
                2'd2:    m_rd = 32'(m_mask);
                2'd3:    m_rd = 32'(m_ec);
                default: m_rd = '0;
            endcase
            m_irq  = |(m_ec & m_mask);
            m_ec   = (m_ec & ~clr) | (m_prev & ~deb_pre);
            m_prev = deb_pre;
            if (wr && bus_if.address == 2'd2) m_mask = bus_if.writedata[W-1:0];
            // A bit flips once its synchronised value has disagreed for DC edges in a row.
            m_hist.push_back(m_s2);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            if (m_hist.size() == DC) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) m_deb[b] = ~m_deb[b];
                end
            end
            m_s2 = m_s1;
            m_s1 = in_port;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_port = '1;
        bus_set(1'b0, 1'b1, 2'd0, '0);
        model_reset();
        #2;
        chk++;
        if ({bus_if.readdata, irq} !== 33'd0) begin
            fail++;
            $display("FAIL reset_state rd=%h irq=%b want rd=0 irq=0", bus_if.readdata, irq);
        end
        #10 reset_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk++;
            if (bus_if.readdata !== 32'h3) begin
                fail++;
                $display("FAIL reset_data cyc=%0d rd=%h want 3", c, bus_if.readdata);
            end
        end
        bus_if.address = 2'd3;
        tick();
        tick();
        chk++;
        if ({bus_if.readdata, irq} !== {m_rd, m_irq} || bus_if.readdata !== 32'h0) begin
            fail++;
            $display("FAIL reset_no_edge rd=%h irq=%b want rd=0 irq=0", bus_if.readdata, irq);
        end
    endtask

    task automatic settle_and_clear();
        in_port = '1;
        bus_set(1'b0, 1'b1, 2'd0, '0);
        for (int c = 0; c < 10; c++) tick();
        bus_set(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        tick();
        bus_set(1'b0, 1'b1, 2'd0, '0);
        tick();
    endtask

    task automatic test_press();
        in_port = 2'b10;
        bus_set(1'b0, 1'b1, 2'd0, '0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk++;
            if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
                fail++;
                $display("FAIL press_model cyc=%0d rd=%h irq=%b want rd=%h irq=%b",
                         c, bus_if.readdata, irq, m_rd, m_irq);
            end
`ifdef PB_EDGE_PIO_DEBOUNCE_EN
            if (c >= 6) begin
                chk++;
                if (bus_if.readdata !== ((c == 7) ? 32'h2 : 32'h3)) begin
                    fail++;
                    $display("FAIL press_latency cyc=%0d rd=%h want %h", c, bus_if.readdata,
                             (c == 7) ? 32'h2 : 32'h3);
                end
            end
`endif
        end
        bus_if.address = 2'd3;
        tick();
        chk++;
        if (bus_if.readdata !== 32'h1) begin
            fail++;
            $display("FAIL press_edgecap rd=%h want 1", bus_if.readdata);
        end
        settle_and_clear();
    endtask

    task automatic test_glitch();
        bus_set(1'b0, 1'b1, 2'd0, '0);
        in_port = 2'b10;
        for (int c = 1; c <= 12; c++) begin
            if (c == 4) in_port = 2'b11;
            tick();
            chk++;
            if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
                fail++;
                $display("FAIL glitch_model cyc=%0d rd=%h irq=%b want rd=%h irq=%b",
                         c, bus_if.readdata, irq, m_rd, m_irq);
            end
        end
        bus_if.address = 2'd3;
        tick();
`ifdef PB_EDGE_PIO_DEBOUNCE_EN
        chk++;
        if (bus_if.readdata !== 32'h0) begin
            fail++;
            $display("FAIL glitch_edgecap rd=%h want 0", bus_if.readdata);
        end
`endif
        settle_and_clear();
    endtask

    task automatic test_irq();
        bus_set(1'b1, 1'b0, 2'd2, 32'h1);
        tick();
        bus_set(1'b0, 1'b1, 2'd2, '0);
        tick();
        chk++;
        if (bus_if.readdata !== 32'h1) begin
            fail++;
            $display("FAIL irq_mask_rd rd=%h want 1", bus_if.readdata);
        end
        bus_if.address = 2'd3;
        in_port = 2'b10;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk++;
            if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
                fail++;
                $display("FAIL irq_model cyc=%0d rd=%h irq=%b want rd=%h irq=%b",
                         c, bus_if.readdata, irq, m_rd, m_irq);
            end
`ifdef PB_EDGE_PIO_DEBOUNCE_EN
            if (c == 7 || c == 8) begin
                chk++;
                if (irq !== (c == 8)) begin
                    fail++;
                    $display("FAIL irq_assert cyc=%0d irq=%b want %b", c, irq, c == 8);
                end
            end
`endif
        end
        bus_set(1'b1, 1'b0, 2'd3, 32'h1);
        tick();
        bus_set(1'b0, 1'b1, 2'd3, '0);
        tick();
        chk++;
        if ({bus_if.readdata, irq} !== {32'h0, 1'b0} ||
            {bus_if.readdata, irq} !== {m_rd, m_irq}) begin
            fail++;
            $display("FAIL irq_clear rd=%h irq=%b want rd=0 irq=0", bus_if.readdata, irq);
        end
        bus_set(1'b1, 1'b0, 2'd2, 32'h0);
        tick();
        settle_and_clear();
    endtask

    task automatic test_set_wins();
        bus_set(1'b0, 1'b1, 2'd3, '0);
        in_port = 2'b01;
        for (int c = 0; c < 8; c++) tick();
        in_port = 2'b11;
        for (int c = 0; c < 8; c++) tick();
        in_port = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            // The RW1C write coincides with the edge that captures the second press.
            if (c == 7) bus_set(1'b1, 1'b0, 2'd3, 32'h2);
            tick();
        end
        bus_set(1'b0, 1'b1, 2'd3, '0);
        tick();
        chk++;
        if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
            fail++;
            $display("FAIL setwins_model rd=%h irq=%b want rd=%h irq=%b",
                     bus_if.readdata, irq, m_rd, m_irq);
        end
`ifdef PB_EDGE_PIO_DEBOUNCE_EN
        chk++;
        if (bus_if.readdata[1] !== 1'b1) begin
            fail++;
            $display("FAIL setwins_bit1 rd=%h want bit1=1", bus_if.readdata);
        end
`endif
        settle_and_clear();
    endtask

    task automatic test_reset_mid();
        bus_set(1'b0, 1'b1, 2'd0, '0);
        in_port = 2'b10;
        for (int c = 0; c < 4; c++) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk++;
        if ({bus_if.readdata, irq} !== 33'd0) begin
            fail++;
            $display("FAIL rstmid_state rd=%h irq=%b want rd=0 irq=0", bus_if.readdata, irq);
        end
        #10 reset_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk++;
            if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
                fail++;
                $display("FAIL rstmid_model cyc=%0d rd=%h irq=%b want rd=%h irq=%b",
                         c, bus_if.readdata, irq, m_rd, m_irq);
            end
`ifdef PB_EDGE_PIO_DEBOUNCE_EN
            if (c == 6 || c == 7) begin
                chk++;
                if (bus_if.readdata !== ((c == 7) ? 32'h2 : 32'h3)) begin
                    fail++;
                    $display("FAIL rstmid_latency cyc=%0d rd=%h want %h", c, bus_if.readdata,
                             (c == 7) ? 32'h2 : 32'h3);
                end
            end
`endif
        end
        settle_and_clear();
    endtask

    task automatic test_no_debounce();
        bus_set(1'b0, 1'b1, 2'd0, '0);
        in_port = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            tick();
            in_port = 2'b11;
            chk++;
            if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
                fail++;
                $display("FAIL nodeb_model cyc=%0d rd=%h want %h", c, bus_if.readdata, m_rd);
            end
        end
`ifndef PB_EDGE_PIO_DEBOUNCE_EN
        chk++;
        if (bus_if.readdata !== 32'h2) begin
            fail++;
            $display("FAIL nodeb_latency rd=%h want 2", bus_if.readdata);
        end
        bus_if.address = 2'd3;
        tick();
        chk++;
        if (bus_if.readdata !== 32'h1) begin
            fail++;
            $display("FAIL nodeb_edgecap rd=%h want 1", bus_if.readdata);
        end
`endif
        settle_and_clear();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
            bus_set(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom), 32'($urandom));
            tick();
            chk++;
            if ({bus_if.readdata, irq} !== {m_rd, m_irq}) begin
                fail++;
                $display("FAIL random_model cyc=%0d rd=%h irq=%b want rd=%h irq=%b",
                         c, bus_if.readdata, irq, m_rd, m_irq);
            end
        end
        settle_and_clear();
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_irq();
        test_set_wins();
        test_reset_mid();
        test_no_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end

endmodule

// File: doc/pb_edge_pio.md
PB_EDGE_PIO -- requirements
Module: pb_edge_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of pushbutton channels, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000: required stable clk cycles before a debounced bit changes, >=2.
REQ-003 SHALL have port clk  input  1: clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  2: Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1: slave select; qualifies write.
REQ-007 SHALL have port write_n  input  1: write strobe, active-low.
REQ-008 SHALL have port writedata  input  32: write data.
REQ-009 SHALL have port readdata  output  32: registered read data.
REQ-010 SHALL have port in_port  input  WIDTH: asynchronous pushbutton inputs, active-low.
REQ-011 SHALL have port irq  output  1: level interrupt, active-high.

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchroniser.
REQ-013 SHALL, per bit, increment a debounce counter while synchronised value differs from debounced value, and clear it to 0 otherwise.
REQ-014 SHALL load debounced bit with synchronised bit, and clear the counter, in the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing.
REQ-015 SHALL give in_port-to-debounced latency of exactly 2+DEBOUNCE_CYCLES cycles for a clean step.
REQ-016 SHALL register map: 0 = debounced data (RO), 1 = reserved (reads 0), 2 = irqmask[WIDTH-1:0] (RW), 3 = edgecapture[WIDTH-1:0] (RW1C).
REQ-017 SHALL update readdata every cycle from address, regardless of chipselect: one-cycle read latency, bits 31:WIDTH zero.
REQ-018 SHALL perform a write when chipselect=1 and write_n=0; writes to addresses 0 and 1 are ignored.
REQ-019 SHALL set edgecapture[i] in the cycle after debounced[i] goes 1->0 (press); rising transitions set nothing.
REQ-020 SHALL clear edgecapture[i] on a write to address 3 with writedata[i]=1; writedata[i]=0 leaves the bit unchanged.
REQ-021 SHALL let set win over clear when both occur in the same cycle on the same bit.
REQ-022 SHALL drive irq = OR of (edgecapture & irqmask), registered: asserted one cycle after the contributing bit/mask change.
REQ-023 SHALL not saturate or wrap the counter: width ceil(log2(DEBOUNCE_CYCLES)), max value DEBOUNCE_CYCLES-1.

Reset
REQ-024 SHALL reset asynchronously on reset_n=0: synchroniser flops and debounced data all-ones (released), counters 0, irqmask 0, edgecapture 0, readdata 0, irq 0.
REQ-025 SHALL produce no edgecapture on reset release when buttons are released; a button held through reset SHALL register one press after debounce.
REQ-026 SHALL, on reset mid-debounce, discard the partial count.

Configuration
REQ-027 SHALL, with macro PB_EDGE_PIO_DEBOUNCE_EN defined, implement REQ-013..REQ-015 and REQ-023.
REQ-028 SHALL, with PB_EDGE_PIO_DEBOUNCE_EN undefined, take debounced = synchronised value directly (latency 2), DEBOUNCE_CYCLES unused, no counters synthesised.

Structure
REQ-029 SHALL place register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and data width 32 in shared package pb_edge_pio_pkg.
REQ-030 SHALL implement the per-bit debounce in sub-module pb_debounce (1 bit, parameter DEBOUNCE_CYCLES), instanced WIDTH times via generate.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-031 SHALL: in_port 2'b11->2'b10 held -> readdata at address 0 reads 0x2 after 6+1 cycles; edgecapture=0x1.
REQ-032 SHALL: bit0 glitch low for 3 cycles then high -> data stays 0x3, edgecapture stays 0.
REQ-033 SHALL: irqmask=0x1, bit0 press -> irq=1; write 0x1 to address 3 -> edgecapture 0, irq=0 next cycle.
REQ-034 SHALL: bit1 press completes the same cycle as RW1C write 0x2 -> edgecapture[1]=1 (set wins).
REQ-035 SHALL: reset_n pulsed low mid-count, button still held -> no press until a full 6 cycles after release; readdata=0 during reset.
REQ-036 SHALL: macro undefined, bit0 low for 1 cycle -> data bit0 reads 0 after 2+1 cycles; edgecapture=0x1.
